// File: rtl/vga_fb_prefetch.sv
// vga_fb_prefetch
//  Framebuffer prefetch engine. Walks a 2-D region (base, words per line, line
//  stride) one word at a time over the fb_access/fb_ack handshake and stores the
//  returned words in a show-ahead FIFO that the pixel renderer drains.
//
//  Parameters: DATA_W word width, ADDR_W word-address width (address sums wrap),
//              DEPTH FIFO depth (power of two, >= 2).
//  Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   enable                       allow new fetch requests
//   frame_start                  1-cycle pulse: flush FIFO, restart walk at base_addr
//   base_addr, words_per_line,
//   line_stride                  frame geometry, latched on frame_start
//   fb_access/fb_address         request + address, held until fb_ack
//   fb_ack/fb_data               request completion and returned word
//   rd_en/rd_data/rd_valid       show-ahead FIFO read side
//   level                        words held
//   underflow                    1-cycle pulse on rd_en while empty
//  Optional: define VGA_FB_PREFETCH_STATS_EN to add underflow_count[15:0]
//  (saturating, cleared on frame_start).
module vga_fb_prefetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     frame_start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        words_per_line,
    input  logic [ADDR_W-1:0]        line_stride,
    output logic                     fb_access,
    output logic [ADDR_W-1:0]        fb_address,
    input  logic                     fb_ack,
    input  logic [DATA_W-1:0]        fb_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
`ifdef VGA_FB_PREFETCH_STATS_EN
    output logic [15:0]              underflow_count,
`endif
    output logic                     underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t state;

    logic [ADDR_W-1:0] line_addr, walk_addr, col, wpl_q, stride_q;
    logic [ADDR_W-1:0] line_nxt, walk_nxt, col_nxt, wpl_last;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] head_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              push, pop;

    // A word is kept only when it answers a request of the current frame and
    // no flush happens on the same edge; flush also suppresses pops.
    assign push     = (state == REQ) && fb_ack && !frame_start;
    assign pop      = rd_en && rd_valid && !frame_start;
    assign wpl_last = (wpl_q == '0) ? '0 : wpl_q - 1'b1;   // zero width acts as one

    // Next walk position (address of the next word to request).
    always_comb begin
        line_nxt = line_addr;
        walk_nxt = walk_addr;
        col_nxt  = col;
        if (frame_start) begin
            line_nxt = base_addr;
            walk_nxt = base_addr;
            col_nxt  = '0;
        end else if (push) begin
            if (col == wpl_last) begin
                line_nxt = line_addr + stride_q;
                walk_nxt = line_nxt;
                col_nxt  = '0;
            end else begin
                walk_nxt = walk_addr + 1'b1;
                col_nxt  = col + 1'b1;
            end
        end
    end

    // Registered show-ahead head: follows the word that will be at the head
    // after this edge; holds when the FIFO becomes or stays empty.
    always_comb begin
        head_nxt = rd_data;
        if (pop) begin
            if (level > LVL_ONE)
                head_nxt = mem[rd_ptr + 1'b1];
            else if (push)
                head_nxt = fb_data;
        end else if (push && level == '0) begin
            head_nxt = fb_data;
        end
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + LVL_ONE;
        else if (pop && !push)
            level_nxt = level - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= fb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fb_access  <= 1'b0;
            fb_address <= '0;
            line_addr  <= '0;
            walk_addr  <= '0;
            col        <= '0;
            wpl_q      <= '0;
            stride_q   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            underflow  <= 1'b0;
        end else begin
            line_addr <= line_nxt;
            walk_addr <= walk_nxt;
            col       <= col_nxt;
            underflow <= rd_en && !rd_valid;
            rd_data   <= head_nxt;
            if (frame_start) begin
                wpl_q    <= words_per_line;
                stride_q <= line_stride;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                rd_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level    <= level_nxt;
                rd_valid <= (level_nxt != '0);
            end
            // The address on the bus is frozen for an outstanding request
            // (including one being drained); otherwise it tracks the walk.
            if (!(fb_access && !fb_ack))
                fb_address <= walk_nxt;
            case (state)
                IDLE: if (enable && level < LVL_FULL && !frame_start) begin
                    state     <= REQ;
                    fb_access <= 1'b1;
                end
                REQ: if (fb_ack) begin
                    state     <= IDLE;
                    fb_access <= 1'b0;
                end else if (frame_start) begin
                    state     <= DRAIN;
                end
                DRAIN: if (fb_ack) begin
                    state     <= IDLE;
                    fb_access <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    fb_access <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_FB_PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            underflow_count <= '0;
        else if (frame_start)
            underflow_count <= '0;
        else if (rd_en && !rd_valid && underflow_count != 16'hFFFF)
            underflow_count <= underflow_count + 16'd1;
    end
`endif

endmodule
